// File: rtl/not4_bist.sv
// ---------------------------------------------------------------------------
// not4_bist -- built-in self-test engine for the 4-bit dual-lane NOT unit.
//
// A start pulse launches a run.
// - Each vector is driven onto a/b and held for SETTLE_CYCLES cycles.
// - x/y are then sampled in a one-cycle CHECK step.
// - Mismatching vectors are counted, saturating at 255.
// - The first failing {a,b} is captured.
//
// Parameters:
//   NUM_VECTORS   vectors per run (1..256, capped at 255 in LFSR mode)
//   SETTLE_CYCLES hold cycles per vector before sampling (1..15)
//
// Optional build macro:
//   NOT4_BIST_LFSR_EN  vectors come from an 8-bit Fibonacci LFSR
//                      (x^8+x^6+x^5+x^4+1, seeded 0x01) instead of a counter
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      starts a run when sampled high in IDLE or DONE
//   a, b       operands to NOT4 (held after a run, cleared only by reset)
//   x, y       NOT4 results
//   busy       run in progress
//   done       run complete (sticky until the next accepted start)
//   pass       no mismatches in the run (meaningful while done)
//   err_count  failing vectors, saturating at 255
//   fail_vec   {a,b} of the first failing vector, 0 if none
// ---------------------------------------------------------------------------
module not4_bist #(
  parameter int NUM_VECTORS   = 256,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] a,
  output logic [3:0] b,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] fail_vec
);

`ifdef NOT4_BIST_LFSR_EN
  // The LFSR never reaches zero, so at most 255 distinct vectors exist.
  localparam int NUM_EFF = (NUM_VECTORS > 255) ? 255 : NUM_VECTORS;
`else
  localparam int NUM_EFF = NUM_VECTORS;
`endif
  localparam logic [7:0] LAST_IDX    = 8'(NUM_EFF - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q;        // vectors completed so far in this run
  logic [3:0]  settle_q;     // cycles spent in APPLY for the current vector
  logic [7:0]  err_q;
  logic [7:0]  fail_vec_q;
  logic        pass_q;
  logic [7:0]  vec;          // {a,b} currently driven
  logic        start_run;
  logic        vec_fail;

`ifdef NOT4_BIST_LFSR_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign vec     = lfsr_q;
`else
  assign vec     = idx_q;
`endif

  assign a = vec[7:4];
  assign b = vec[3:0];

  assign start_run = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  // Case inequality so an X/Z on the result bus counts as a failure.
  assign vec_fail  = (x !== ~a) || (y !== ~b);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_APPLY;
      S_APPLY:        if (settle_q == SETTLE_LAST) state_d = S_CHECK;
      S_CHECK:        state_d = (idx_q == LAST_IDX) ? S_DONE : S_APPLY;
      default:        state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q == S_APPLY) || (state_q == S_CHECK);
    done      = (state_q == S_DONE);
    pass      = pass_q;
    err_count = err_q;
    fail_vec  = fail_vec_q;
  end

  // Datapath: vector source, settle timer, result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      settle_q   <= '0;
      err_q      <= '0;
      fail_vec_q <= '0;
      pass_q     <= 1'b0;
`ifdef NOT4_BIST_LFSR_EN
      lfsr_q     <= '0;
`endif
    end else if (start_run) begin
      idx_q      <= '0;
      settle_q   <= '0;
      err_q      <= '0;
      fail_vec_q <= '0;
      pass_q     <= 1'b0;
`ifdef NOT4_BIST_LFSR_EN
      lfsr_q     <= 8'h01;
`endif
    end else begin
      case (state_q)
        S_APPLY: begin
          settle_q <= (settle_q == SETTLE_LAST) ? 4'd0 : settle_q + 4'd1;
        end
        S_CHECK: begin
          if (vec_fail) begin
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            // err_q is still zero only before the first failure of the run.
            if (err_q == 8'd0) fail_vec_q <= vec;
          end
          if (idx_q == LAST_IDX) begin
            pass_q <= (err_q == 8'd0) && !vec_fail;
          end else begin
            idx_q  <= idx_q + 8'd1;
`ifdef NOT4_BIST_LFSR_EN
            lfsr_q <= {lfsr_q[6:0], lfsr_fb};
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_not4_bist.sv
module tb_not4_bist;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a, b, x, y;
  logic       busy, done, pass;
  logic [7:0] err_count, fail_vec;

  // Fault injection on the NOT4 model: out = ((~in & and) | or) ^ xor
  logic [3:0] x_and, x_or, x_xor, y_and, y_or, y_xor;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  not4_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .x(x), .y(y),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  assign x = ((~a & x_and) | x_or) ^ x_xor;
  assign y = ((~b & y_and) | y_or) ^ y_xor;

  typedef struct {
    string      name;
    logic [3:0] xa, xo, xx, ya, yo, yx;
    int         exp_err;
    int         exp_fail;
    int         exp_pass;
  } case_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s = %0h", nm, act);
    end
  endtask

  task automatic set_fault(input logic [3:0] xa, xo, xx, ya, yo, yx);
    x_and = xa; x_or = xo; x_xor = xx;
    y_and = ya; y_or = yo; y_xor = yx;
  endtask

  // Reference: walk every {a,b} from 0 to 255, apply the fault, count.
  task automatic ref_model(output int e, output int f, output int p);
    e = 0; f = 0;
    for (int v = 0; v < 256; v++) begin
      int av, bv, xv, yv;
      av = v / 16;
      bv = v % 16;
      xv = ((((15 - av) & x_and) | x_or) ^ x_xor) & 15;
      yv = ((((15 - bv) & y_and) | y_or) ^ y_xor) & 15;
      if (xv != 15 - av || yv != 15 - bv) begin
        if (e == 0) f = v;
        if (e < 255) e++;
      end
    end
    p = (e == 0) ? 1 : 0;
  endtask

  // Launch a run, measure its length, check results.
  // repulse_at > 0 re-asserts start for one cycle at that cycle of the run.
  task automatic run_and_check(input string nm, input int exp_err, input int exp_fail,
                               input int exp_pass, input int repulse_at);
    int cycles;
    bit busy_bad;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, ".busy_on_accept"}, busy, 1);
    chk({nm, ".done_cleared"}, done, 0);
    cycles = 0;
    busy_bad = 0;
    while (!done && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
      if (!done && !busy) busy_bad = 1;
      start = (cycles == repulse_at);
    end
    start = 1'b0;
    chk({nm, ".run_cycles"}, cycles, 512);
    chk({nm, ".busy_held"}, busy_bad, 0);
    chk({nm, ".busy_at_done"}, busy, 0);
    chk({nm, ".err_count"}, err_count, exp_err);
    chk({nm, ".fail_vec"}, fail_vec, exp_fail);
    chk({nm, ".pass"}, pass, exp_pass);
    chk({nm, ".ab_held"}, {a, b}, 8'hFF);
  endtask

  case_t tbl[4];

  initial begin
    tbl[0] = '{"fault_free",  4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0,   0, 8'h00, 1};
    tbl[1] = '{"x0_stuck0",   4'hE, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 128, 8'h00, 0};
    tbl[2] = '{"y_stuck_F",   4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 240, 8'h01, 0};
    tbl[3] = '{"all_wrong",   4'hF, 4'h0, 4'h1, 4'hF, 4'h0, 4'h0, 255, 8'h00, 0};

    set_fault(4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.pass", pass, 0);
    chk("reset.err_count", err_count, 0);
    chk("reset.fail_vec", fail_vec, 0);
    chk("reset.ab", {a, b}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table; runs after the first start from DONE.
    for (int i = 0; i < 4; i++) begin
      set_fault(tbl[i].xa, tbl[i].xo, tbl[i].xx, tbl[i].ya, tbl[i].yo, tbl[i].yx);
      run_and_check(tbl[i].name, tbl[i].exp_err, tbl[i].exp_fail, tbl[i].exp_pass, 0);
    end

    // Randomized faults checked against the reference model.
    for (int r = 0; r < 4; r++) begin
      int e, f, p;
      set_fault(4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      ref_model(e, f, p);
      run_and_check($sformatf("random%0d", r), e, f, p, 0);
    end

    // Start re-pulsed at cycle 50 is ignored.
    set_fault(4'hE, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
    run_and_check("repulse50", 128, 8'h00, 0, 50);

    // Reset at cycle 100 of a failing run: everything clears immediately.
    set_fault(4'hF, 4'h0, 4'h1, 4'hF, 4'h0, 4'h0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("midrun.err_count", err_count, 50);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.pass", pass, 0);
    chk("midrst.err_count", err_count, 0);
    chk("midrst.fail_vec", fail_vec, 0);
    chk("midrst.ab", {a, b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_fault(4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
    run_and_check("after_rst", 0, 8'h00, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/not4_bist.md
# not4_bist

Hardware built-in self-test engine for the 4-bit dual-lane NOT unit (NOT4) in the four-bit ALU. The block sits beside NOT4 in the ALU logic slice. On a start pulse it drives a sequence of operand pairs onto NOT4's `a`/`b` inputs and samples `x`/`y` after a programmable settle time. It checks `x == ~a` and `y == ~b`, counts mismatches, and reports pass/fail plus the first failing vector. Its outputs feed the ALU's test/status register.

## Interface
Parameters:
- `NUM_VECTORS`, default 256: number of vectors applied per run. Legal range 1..256.
- `SETTLE_CYCLES`, default 1: number of cycles each vector is held before it is sampled. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  starts a run when sampled high in IDLE or DONE.
- `a`  out  4  operand A to NOT4.
- `b`  out  4  operand B to NOT4.
- `x`  in  4  NOT4 result for A.
- `y`  in  4  NOT4 result for B.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high once a run completes; sticky until the next accepted start.
- `pass`  out  1  high when `err_count == 0`; valid only while `done` is high.
- `err_count`  out  8  mismatching vectors in the run; saturates at 255.
- `fail_vec`  out  8  `{a,b}` of the first failing vector; 0 if no vector failed.

## Operation
- States:
  - IDLE: waits for `start`.
  - APPLY: drives the current vector for SETTLE_CYCLES cycles.
  - CHECK: samples `x`/`y` and compares.
  - DONE: results held.
- Transitions:
  - IDLE/DONE → APPLY on `start`=1. Clears `err_count`, `fail_vec`, `done` and the vector index; loads vector 0.
  - APPLY → CHECK after SETTLE_CYCLES cycles.
  - CHECK → APPLY (next vector) while index < NUM_VECTORS−1.
  - CHECK → DONE after the last vector.
- Vector source (default): an 8-bit index counter. `a = idx[7:4]`, `b = idx[3:0]`, so vector 0 = `{0,0}` and the index increments by 1.
- Compare in CHECK: a vector fails when `x !== ~a` or `y !== ~b`. A vector counts as one error even if both lanes are wrong.
- On the first failure, `fail_vec <= {a,b}`. Later failures do not update `fail_vec`.
- `err_count` increments per failing vector and holds at 255.
- `start` is ignored while `busy`=1.
- `a`/`b` hold the last vector in DONE and return to 0 only on reset.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0. State is IDLE.
- `busy` rises on the edge that accepts `start` and falls on the edge that sets `done`.
- Each vector takes SETTLE_CYCLES + 1 cycles.
- `done` rises exactly NUM_VECTORS × (SETTLE_CYCLES + 1) cycles after the accepting edge. With default parameters this is 512 cycles.
- `pass`, `err_count` and `fail_vec` are registered and stable from the cycle `done` rises.
- Reset asserted mid-run: all outputs go to their reset values immediately (asynchronously). No partial results are kept.
- `start` held high in DONE: the block starts a new run on the next edge.

## Configuration
- `NOT4_BIST_LFSR_EN` defined:
  - Vectors come from an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seeded 0x01 on start; `{a,b}` = LFSR state.
  - The LFSR steps once per vector.
  - NUM_VECTORS is capped at 255; all-zero is never applied.
- `NOT4_BIST_LFSR_EN` undefined:
  - Linear counter as described in Operation.
  - No LFSR logic is present.

## Test plan
- Fault-free NOT4 attached, defaults, `start` pulsed:
  - `busy`=1 for 512 cycles, then `done`=1, `pass`=1, `err_count`=0, `fail_vec`=0x00.
- `x[0]` forced to 0:
  - `done` → `err_count`=128, `pass`=0, `fail_vec`=0x00.
- `y` forced to 4'hF:
  - `err_count`=240, `fail_vec`=0x01.
- `x` driven as `~a ^ 4'b0001` (every vector wrong):
  - `err_count` saturates at 255, `fail_vec`=0x00.
- `rst_n` pulsed low at cycle 100 of a run:
  - all outputs return to their reset values at once.
  - A new `start` then completes normally with `pass`=1.
- `start` re-pulsed at cycle 50 of a run:
  - ignored; `done` still rises at cycle 512 with the correct results.
